// File: rtl/sha256_sched.sv
// sha256_sched: round-robin job scheduler for one sha256 core; issues context, offsets reads by job base, returns digest.
// Memory path is one registered cycle each way (no buffering); optional RUN watchdog via SHA256_SCHED_TIMEOUT_EN.
package sha256_pkg;
  typedef struct packed {
    logic [63:0]  length;
    logic [255:0] state;
    logic [31:0]  curlen;
    logic [511:0] buffer;
  } ShaContext;

  localparam logic [255:0] H = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
endpackage

module sha256_sched #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 65535,
  localparam int IDW    = $clog2(NREQ)
) (
  input  logic                  clk_axi,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_vld,
  output logic [NREQ-1:0]       req_rdy,
  input  logic [NREQ*32-1:0]    req_base,
  input  logic [NREQ*32-1:0]    req_len,
  output logic                  core_ctx_vld,
  input  logic                  core_ctx_rdy,
  output sha256_pkg::ShaContext core_ctx,
  input  logic                  core_mem_addr_vld,
  input  logic [31:0]           core_mem_addr,
  output logic                  core_mem_data_vld,
  output logic [31:0]           core_mem_data,
  output logic                  mem_addr_vld,
  output logic [31:0]           mem_addr,
  input  logic                  mem_data_vld,
  input  logic [31:0]           mem_data,
  input  logic                  core_hash_vld,
  output logic                  core_hash_rdy,
  input  logic [255:0]          core_hash,
  output logic                  res_vld,
  input  logic                  res_rdy,
  output logic [IDW-1:0]        res_id,
  output logic [255:0]          res_hash,
  output logic                  res_err,
  output logic                  core_rst,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RUN, DONE} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] last_grant, grant, rr_idx, job_id;
  logic [31:0]    job_base, job_len, sel_base, sel_len;
  logic           found, run, wd_hit;
  logic           maddr_vld_q, mdata_vld_q;
  logic [31:0]    maddr_q, mdata_q;

  // First valid requester after the previous winner.
  always_comb begin
    grant  = last_grant;
    found  = 1'b0;
    rr_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      rr_idx = IDW'((int'(last_grant) + k) % NREQ);
      if (!found && req_vld[rr_idx]) begin
        grant = rr_idx;
        found = 1'b1;
      end
    end
  end

  assign sel_base = req_base[32*grant +: 32];
  assign sel_len  = req_len[32*grant +: 32];
  assign run      = (state == RUN);

  always_ff @(posedge clk_axi) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    req_rdy       = '0;
    core_ctx_vld  = 1'b0;
    core_hash_rdy = 1'b0;
    res_vld       = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          req_rdy[grant] = 1'b1;
          state_nxt      = (sel_len == 32'd0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        core_ctx_vld = 1'b1;
        if (core_ctx_rdy) state_nxt = RUN;
      end
      RUN: begin
        core_hash_rdy = 1'b1;
        if (core_hash_vld || wd_hit) state_nxt = DONE;
      end
      DONE: begin
        res_vld = 1'b1;
        if (res_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Handshakes stay quiet while reset is held, even before the register clears.
    if (rst) begin
      req_rdy       = '0;
      core_ctx_vld  = 1'b0;
      core_hash_rdy = 1'b0;
      res_vld       = 1'b0;
      state_nxt     = IDLE;
    end
  end

  always_ff @(posedge clk_axi) begin
    if (rst) begin
      last_grant  <= IDW'(NREQ - 1);
      job_id      <= '0;
      job_base    <= '0;
      job_len     <= '0;
      res_hash    <= '0;
      res_err     <= 1'b0;
      maddr_vld_q <= 1'b0;
      maddr_q     <= '0;
      mdata_vld_q <= 1'b0;
      mdata_q     <= '0;
    end else begin
      maddr_vld_q <= run && core_mem_addr_vld;
      maddr_q     <= job_base + core_mem_addr;
      mdata_vld_q <= run && mem_data_vld;
      mdata_q     <= mem_data;
      if (|req_rdy) begin
        job_id   <= grant;
        job_base <= sel_base;
        job_len  <= sel_len;
        res_hash <= '0;
        res_err  <= (sel_len == 32'd0);
      end
      if (core_hash_vld && core_hash_rdy) begin
        res_hash <= core_hash;
        res_err  <= 1'b0;
      end else if (wd_hit) begin
        res_hash <= '0;
        res_err  <= 1'b1;
      end
      if (res_vld && res_rdy) last_grant <= job_id;
    end
  end

`ifdef SHA256_SCHED_TIMEOUT_EN
  logic [31:0] wd_cnt;

  always_ff @(posedge clk_axi) begin
    if (rst)                                  wd_cnt <= '0;
    else if (state == ISSUE && core_ctx_rdy)  wd_cnt <= '0;
    else if (run)                             wd_cnt <= wd_cnt + 32'd1;
  end

  // A digest arriving on the limit cycle still wins over the abort.
  assign wd_hit = run && !rst && !core_hash_vld && (wd_cnt == 32'(TIMEOUT));
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT > 0);
  assign wd_hit     = 1'b0;
`endif

  always_comb begin
    core_ctx        = '0;
    core_ctx.length = {29'd0, job_len, 3'd0};
    core_ctx.state  = sha256_pkg::H;
    core_ctx.curlen = job_len;
  end

  assign mem_addr_vld      = maddr_vld_q && run;
  assign mem_addr          = maddr_q;
  assign core_mem_data_vld = mdata_vld_q && run;
  assign core_mem_data     = mdata_q;
  assign res_id            = job_id;
  assign busy              = (state != IDLE);
  assign core_rst          = rst || wd_hit;

endmodule

// File: tb/tb_sha256_sched.sv
// Bench for sha256_sched: plays requesters, sha256 core and memory against a round-robin job model.
module tb_sha256_sched;
  localparam int NREQ = 4;
  localparam int IDW  = $clog2(NREQ);
  localparam logic [255:0] H_REF = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  logic                  clk_axi = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_vld, req_rdy;
  logic [NREQ*32-1:0]    req_base, req_len;
  logic                  core_ctx_vld, core_ctx_rdy;
  sha256_pkg::ShaContext core_ctx;
  logic                  core_mem_addr_vld, core_mem_data_vld, mem_addr_vld, mem_data_vld;
  logic [31:0]           core_mem_addr, core_mem_data, mem_addr, mem_data;
  logic                  core_hash_vld, core_hash_rdy, res_vld, res_rdy, res_err, core_rst, busy;
  logic [255:0]          core_hash, res_hash;
  logic [IDW-1:0]        res_id;

  always #5 clk_axi = ~clk_axi;

  sha256_sched #(.NREQ(NREQ), .TIMEOUT(100)) dut (
    .clk_axi(clk_axi), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy),
    .req_base(req_base), .req_len(req_len), .core_ctx_vld(core_ctx_vld),
    .core_ctx_rdy(core_ctx_rdy), .core_ctx(core_ctx), .core_mem_addr_vld(core_mem_addr_vld),
    .core_mem_addr(core_mem_addr), .core_mem_data_vld(core_mem_data_vld),
    .core_mem_data(core_mem_data), .mem_addr_vld(mem_addr_vld), .mem_addr(mem_addr),
    .mem_data_vld(mem_data_vld), .mem_data(mem_data), .core_hash_vld(core_hash_vld),
    .core_hash_rdy(core_hash_rdy), .core_hash(core_hash), .res_vld(res_vld), .res_rdy(res_rdy),
    .res_id(res_id), .res_hash(res_hash), .res_err(res_err), .core_rst(core_rst), .busy(busy)
  );

  int total = 0;
  int bad   = 0;
  int last_g;
  int w, g, seen;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_axi);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [31:0] b, input logic [31:0] l);
    req_vld[i]          = v;
    req_base[32*i +: 32] = b;
    req_len[32*i +: 32]  = l;
  endtask

  // Smallest rotation past the last winner that holds a valid request.
  function automatic int rr_pick(input logic [NREQ-1:0] m, input int last);
    int r = -1;
    for (int k = NREQ; k >= 1; k--) if (m[(last + k) % NREQ]) r = (last + k) % NREQ;
    return r;
  endfunction

  task automatic do_job(input bit keep, input int hold, input int nmem, output int gid);
    int n, eg, dly;
    logic [31:0] b, l, o, d, ea;
    logic ev, edv;
    logic [255:0] h, eh, emask;
    #1;
    n = 0;
    while (req_rdy == '0 && n < 40) begin step(); n++; end
    eg = rr_pick(req_vld, last_g);
    gid = eg;
    emask = '0;
    if (eg >= 0) emask[eg] = 1'b1;
    chk("grant", 256'(req_rdy), emask);
    if (req_rdy == '0 || eg < 0) return;
    b = req_base[32*eg +: 32];
    l = req_len[32*eg +: 32];
    h = '0;
    step();
    if (!keep) req_vld[eg] = 1'b0;
    chk("busy_job", 256'(busy), 256'(1));
    if (l == 32'd0) begin
      chk("zl_no_ctx", 256'(core_ctx_vld), 256'(0));
    end else begin
      chk("ctx_vld", 256'(core_ctx_vld), 256'(1));
      chk("ctx_len", 256'(core_ctx.length), 256'(64'(l) * 64'd8));
      chk("ctx_cur", 256'(core_ctx.curlen), 256'(l));
      chk("ctx_state", core_ctx.state, H_REF);
      chk("ctx_buf", 256'(|core_ctx.buffer), 256'(0));
      dly = $urandom_range(0, 2);
      repeat (dly) begin
        step();
        chk("ctx_hold", 256'(core_ctx_vld), 256'(1));
      end
      core_ctx_rdy = 1'b1;
      step();
      core_ctx_rdy = 1'b0;
      chk("hash_rdy", 256'(core_hash_rdy), 256'(1));
      for (int i = 0; i < nmem; i++) begin
        ev  = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        o   = (i == 0) ? 32'd0 : $urandom;
        edv = 1'($urandom_range(0, 1));
        d   = $urandom;
        ea  = b + o;
        core_mem_addr_vld = ev;
        core_mem_addr     = o;
        mem_data_vld      = edv;
        mem_data          = d;
        step();
        chk("maddr_vld", 256'(mem_addr_vld), 256'(ev));
        if (ev) chk("maddr", 256'(mem_addr), 256'(ea));
        chk("mdata_vld", 256'(core_mem_data_vld), 256'(edv));
        if (edv) chk("mdata", 256'(core_mem_data), 256'(d));
      end
      h = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      core_hash_vld     = 1'b1;
      core_hash         = h;
      core_mem_addr_vld = 1'b1;
      mem_data_vld      = 1'b1;
      step();
      core_hash_vld     = 1'b0;
      chk("drop_addr", 256'(mem_addr_vld), 256'(0));
      chk("drop_data", 256'(core_mem_data_vld), 256'(0));
      core_mem_addr_vld = 1'b0;
      mem_data_vld      = 1'b0;
    end
    eh = (l == 32'd0) ? '0 : h;
    for (int k = 0; k <= hold; k++) begin
      if (k > 0) step();
      chk("res_vld", 256'(res_vld), 256'(1));
      chk("res_id", 256'(res_id), 256'(eg));
      chk("res_hash", res_hash, eh);
      chk("res_err", 256'(res_err), 256'(l == 32'd0));
      chk("rdy_blk", 256'(req_rdy), 256'(0));
      chk("busy_done", 256'(busy), 256'(1));
    end
    res_rdy = 1'b1;
    step();
    res_rdy = 1'b0;
    chk("idle_busy", 256'(busy), 256'(0));
    chk("idle_res", 256'(res_vld), 256'(0));
    last_g = eg;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    last_g = NREQ - 1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "bench stalled");
  end

  initial begin
    rst = 1'b1;
    req_vld = '1;
    req_base = '0;
    req_len = {NREQ{32'd8}};
    core_ctx_rdy = 1'b0;
    core_mem_addr_vld = 1'b0;
    core_mem_addr = '0;
    mem_data_vld = 1'b0;
    mem_data = '0;
    core_hash_vld = 1'b0;
    core_hash = '0;
    res_rdy = 1'b0;
    repeat (3) step();
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_req_rdy", 256'(req_rdy), 256'(0));
    chk("rst_res_vld", 256'(res_vld), 256'(0));
    chk("rst_ctx_vld", 256'(core_ctx_vld), 256'(0));
    chk("rst_hash_rdy", 256'(core_hash_rdy), 256'(0));
    chk("rst_mem_vld", 256'(mem_addr_vld), 256'(0));
    chk("rst_res_hash", res_hash, 256'(0));
    chk("rst_res_err", 256'(res_err), 256'(0));
    chk("rst_res_id", 256'(res_id), 256'(0));
    chk("rst_core_rst", 256'(core_rst), 256'(1));
    rst = 1'b0;
    req_vld = '0;
    last_g = NREQ - 1;
    step();
    chk("core_rst_low", 256'(core_rst), 256'(0));

    // Single job on requester 2 at base 0x1000, 64 bytes.
    set_req(2, 1'b1, 32'h0000_1000, 32'd64);
    do_job(1'b0, 0, 3, g);
    chk("t_single_id", 256'(g), 256'(2));

    // All requesters held valid: strict rotation from a fresh reset.
    apply_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, $urandom, 32'($urandom_range(1, 4096)));
    for (int j = 0; j < 8; j++) begin
      do_job(1'b1, 0, 2, g);
      if (j == 7) req_vld = '0;
      chk("rr_seq", 256'(g), 256'(j % NREQ));
    end

    // Zero-length job skips the core.
    set_req(1, 1'b1, 32'h0000_4000, 32'd0);
    do_job(1'b0, 1, 0, g);

    // Result held back for 10 cycles.
    set_req(0, 1'b1, 32'hffff_fff0, 32'd100);
    do_job(1'b0, 10, 4, g);

    // Reset while the core is running.
    set_req(3, 1'b1, 32'h0000_8000, 32'd32);
    #1;
    w = 0;
    while (!core_ctx_vld && w < 40) begin step(); w++; end
    chk("mid_ctx", 256'(core_ctx_vld), 256'(1));
    core_ctx_rdy = 1'b1;
    step();
    core_ctx_rdy = 1'b0;
    core_mem_addr_vld = 1'b1;
    chk("mid_run", 256'(core_hash_rdy), 256'(1));
    rst = 1'b1;
    step();
    core_mem_addr_vld = 1'b0;
    chk("mid_busy", 256'(busy), 256'(0));
    chk("mid_hash_rdy", 256'(core_hash_rdy), 256'(0));
    chk("mid_req_rdy", 256'(req_rdy), 256'(0));
    chk("mid_mem_vld", 256'(mem_addr_vld), 256'(0));
    chk("mid_res_id", 256'(res_id), 256'(0));
    chk("mid_res_hash", res_hash, 256'(0));
    chk("mid_core_rst", 256'(core_rst), 256'(1));
    rst = 1'b0;
    last_g = NREQ - 1;
    set_req(1, 1'b1, 32'h0000_0100, 32'd5);
    do_job(1'b0, 0, 2, g);
    chk("post_rst_id", 256'(g), 256'(1));
    req_vld = '0;

    // Randomized traffic against the rotation model.
    for (int j = 0; j < 24; j++) begin
      logic [NREQ-1:0] m;
      m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++)
        set_req(i, m[i], $urandom, ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom);
      do_job(1'b0, $urandom_range(0, 2), $urandom_range(1, 5), g);
    end
    req_vld = '0;

`ifdef SHA256_SCHED_TIMEOUT_EN
    // Core never answers: watchdog aborts after 100 RUN cycles.
    set_req(0, 1'b1, 32'h0000_2000, 32'd16);
    #1;
    w = 0;
    while (!core_ctx_vld && w < 40) begin step(); w++; end
    req_vld = '0;
    chk("wd_ctx", 256'(core_ctx_vld), 256'(1));
    core_ctx_rdy = 1'b1;
    step();
    core_ctx_rdy = 1'b0;
    seen = -1;
    for (int c = 0; c < 200 && seen < 0; c++) begin
      if (core_rst) seen = c;
      else step();
    end
    chk("wd_cycle", 256'(seen), 256'(100));
    step();
    chk("wd_pulse", 256'(core_rst), 256'(0));
    chk("wd_res_vld", 256'(res_vld), 256'(1));
    chk("wd_res_err", 256'(res_err), 256'(1));
    chk("wd_res_hash", res_hash, 256'(0));
    chk("wd_res_id", 256'(res_id), 256'(0));
    res_rdy = 1'b1;
    step();
    res_rdy = 1'b0;
    chk("wd_idle", 256'(busy), 256'(0));
    last_g = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sha256_sched.md
SHA256_SCHED -- requirements
Module: sha256_sched

Interface
REQ-001 Parameter NREQ, 4, number of requesters (2..8).
REQ-002 Parameter TIMEOUT, 65535, watchdog limit in cycles (used only with SHA256_SCHED_TIMEOUT_EN).
REQ-003 clk_axi  in  1  single clock; reset is synchronous and active-high.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 req_vld / req_rdy  in / out  NREQ  per-requester job request and accept.
REQ-006 req_base  in  NREQ*32  per-requester message byte base address.
REQ-007 req_len  in  NREQ*32  per-requester message length in bytes.
REQ-008 core_ctx_vld / core_ctx_rdy  out / in  1  context handshake to the sha256 core.
REQ-009 core_ctx  out  sha256_pkg::ShaContext  context for the granted job.
REQ-010 core_mem_addr_vld, core_mem_addr  in  1, 32  core byte-offset read request.
REQ-011 core_mem_data_vld, core_mem_data  out  1, 32  read data returned to the core.
REQ-012 mem_addr_vld, mem_addr  out  1, 32  translated read request to memory.
REQ-013 mem_data_vld, mem_data  in  1, 32  memory read data.
REQ-014 core_hash_vld / core_hash_rdy  in / out  1; core_hash  in  256  core digest.
REQ-015 res_vld / res_rdy  out / in  1; res_id  out  $clog2(NREQ); res_hash  out  256; res_err  out  1.
REQ-016 core_rst  out  1  reset to the sha256 core.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 FSM states IDLE, ISSUE, RUN, DONE, SHALL be one-hot or binary, with IDLE after reset.
REQ-019 IDLE: if any req_vld, grant round-robin starting at (last_grant+1) mod NREQ; pulse req_rdy[g] one cycle; latch base, len, id; go to ISSUE next cycle.
REQ-020 Zero-length grant (req_len==0): skip core, go IDLE->DONE with res_hash=0, res_err=1.
REQ-021 ISSUE: core_ctx_vld=1, core_ctx={length={len,3'b0} as 64 bits, state=sha256_pkg::H, curlen=len, buffer='0}; stable until core_ctx_rdy; then go to RUN.
REQ-022 RUN: mem_addr_vld/mem_addr registered copy of core_mem_addr_vld and (base+core_mem_addr) mod 2^32; one cycle latency.
REQ-023 RUN: core_mem_data_vld/core_mem_data registered copy of mem_data_vld/mem_data; one cycle latency; no buffering, no reordering.
REQ-024 Outside RUN: mem_addr_vld=0, core_mem_data_vld=0; arriving mem_data dropped.
REQ-025 core_hash_rdy=1 only in RUN; on core_hash_vld&&core_hash_rdy latch res_hash, res_err=0, go to DONE.
REQ-026 DONE: res_vld=1, res_id/res_hash/res_err stable until res_rdy; on res_vld&&res_rdy go to IDLE, update last_grant.
REQ-027 New grants SHALL NOT occur before the IDLE cycle following result acceptance; one job in flight.
REQ-028 req_vld deasserted before grant is not serviced; no request is starved beyond NREQ-1 other jobs.

Reset
REQ-029 rst, mid-job included, SHALL force IDLE, last_grant=NREQ-1, zero all valid/ready outputs, res_hash/res_id/res_err=0, busy=0.
REQ-030 core_rst=rst in all configurations (plus abort pulse, REQ-032).

Configuration
REQ-031 Macro SHA256_SCHED_TIMEOUT_EN: when defined, a cycle counter clears on entry to RUN and increments each RUN cycle.
REQ-032 With macro: count==TIMEOUT in RUN -> core_rst pulses one cycle, res_hash=0, res_err=1, go to DONE. Without macro: no counter, RUN waits indefinitely, core_rst=rst.

Verification
REQ-033 req_vld[2]=1, base=0x1000, len=64; core issues offset 0x0 -> ctx.length=512, curlen=64, mem_addr=0x1000 one cycle later, result id=2, err=0.
REQ-034 All four req_vld held high for 8 jobs -> grant order 0,1,2,3,0,1,2,3.
REQ-035 req_len=0 on requester 1 -> no core_ctx_vld, res_vld with id=1, hash=0, err=1.
REQ-036 res_rdy held low 10 cycles in DONE -> res_* stable, req_rdy stays 0, busy=1.
REQ-037 rst asserted in RUN -> next cycle IDLE, all outputs at reset values; following job completes normally.
REQ-038 Macro on, TIMEOUT=100, core never returns hash -> core_rst pulse at cycle 100 of RUN, res_err=1, return to IDLE after res_rdy.
